rr_arb4: RTL and testbench

- Round-robin arbiter that shares one downstream resource among 4 requesters.
- The winner is reported both one-hot (gnt) and encoded (gnt_id, 4-to-2 style), so the resource's input mux selects directly from gnt_id.
- Grants are bounded by a hold limit, so one requester cannot starve the others.
- Sits between the requester ports and the shared resource; the global enable gates all arbitration.

---
 rtl/rr_arb4.sv | 95 +++++++++
 tb/tb_rr_arb4.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - four-way round-robin arbiter with bounded grant hold
module rr_arb4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       gnt_id,
    output logic             gnt_vld,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [1:0]       id_q, id_n;
    logic             vld_q, vld_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    // First set request after position p, scanning p+1 .. p+4 (mod 4); later
    // iterations overwrite, so iterating downwards leaves the nearest winner.
    function automatic logic [1:0] sel(input logic [1:0] p, input logic [3:0] r);
        logic [1:0] idx;
        sel = p;
        for (int i = 4; i >= 1; i--) begin
            idx = p + i[1:0];
            if (r[idx]) sel = idx;
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd3;
            id_q  <= 2'd0;
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            id_q  <= id_n;
            vld_q <= vld_n;
            cnt_q <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        id_n    = id_q;
        vld_n   = vld_q;
        cnt_n   = cnt_q;
        case (state)
            IDLE: begin
                if (en && (|req)) begin
                    id_n    = sel(ptr, req);
                    vld_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (en && req[id_q] && (cnt_q < HOLD_LAST)) begin
                    cnt_n = cnt_q + 1'b1;
                end else begin
                    // Owner is ranked last from here on; hand over without a bubble.
                    ptr_n = id_q;
                    cnt_n = '0;
                    if (en && (|req)) begin
                        id_n = sel(id_q, req);
                    end else begin
                        id_n    = 2'd0;
                        vld_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        gnt      = vld_q ? (4'b0001 << id_q) : 4'b0000;
        gnt_id   = id_q;
        gnt_vld  = vld_q;
        hold_cnt = cnt_q;
    end

endmodule

// File: tb/tb_rr_arb4.sv
// tb/tb_rr_arb4.sv - directed self-checking bench for rr_arb4
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, en1;
    logic [3:0] req, req1;
    logic [3:0] gnt, gnt1;
    logic [1:0] gnt_id, gnt_id1;
    logic       gnt_vld, gnt_vld1;
    logic [3:0] hold_cnt;
    logic [0:0] hold_cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_arb4 #(.MAX_HOLD(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .hold_cnt(hold_cnt)
    );

    rr_arb4 #(.MAX_HOLD(1), .CNT_W(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .req(req1),
        .gnt(gnt1), .gnt_id(gnt_id1), .gnt_vld(gnt_vld1), .hold_cnt(hold_cnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        en = 1'b0; req = 4'b0; en1 = 1'b0; req1 = 4'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({gnt, gnt_id, gnt_vld, hold_cnt} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b id=%0d vld=%b cnt=%0d, expected all zero", gnt, gnt_id, gnt_vld, hold_cnt);
        end
        step();
        checks++;
        if (gnt !== 4'b0 || gnt_vld !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got gnt=%b vld=%b, expected 0000/0", gnt, gnt_vld);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [3] = '{4'b0001, 4'b0100, 4'b0001};
        logic [1:0] exp_i [3] = '{2'd0, 2'd2, 2'd0};
        apply_reset();
        en = 1'b1; req = 4'b0101;
        for (int o = 0; o < 3; o++) begin
            for (int c = 0; c < ((o == 2) ? 1 : 8); c++) begin
                step();
                checks++;
                if (gnt !== exp_g[o] || gnt_id !== exp_i[o] || gnt_vld !== 1'b1 || hold_cnt !== 4'(c)) begin
                    errors++;
                    $display("FAIL rotation owner%0d cyc%0d: got gnt=%b id=%0d vld=%b cnt=%0d, expected gnt=%b id=%0d vld=1 cnt=%0d",
                             o, c, gnt, gnt_id, gnt_vld, hold_cnt, exp_g[o], exp_i[o], c);
                end
            end
        end
    endtask

    task automatic test_single_owner();
        apply_reset();
        en = 1'b1; req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (gnt !== 4'b1000 || gnt_id !== 2'd3 || hold_cnt !== 4'(c % 8)) begin
                errors++;
                $display("FAIL single_owner cyc%0d: got gnt=%b id=%0d cnt=%0d, expected gnt=1000 id=3 cnt=%0d",
                         c, gnt, gnt_id, hold_cnt, c % 8);
            end
        end
    endtask

    task automatic test_owner_drop();
        apply_reset();
        en = 1'b1; req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (gnt !== 4'b0010 || hold_cnt !== 4'(c)) begin
                errors++;
                $display("FAIL drop_hold cyc%0d: got gnt=%b cnt=%0d, expected gnt=0010 cnt=%0d", c, gnt, hold_cnt, c);
            end
        end
        req = 4'b1001;
        step();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || hold_cnt !== 4'd0) begin
            errors++;
            $display("FAIL drop_handover: got gnt=%b id=%0d cnt=%0d, expected gnt=1000 id=3 cnt=0", gnt, gnt_id, hold_cnt);
        end
    endtask

    task automatic test_enable();
        apply_reset();
        en = 1'b1; req = 4'b0100;
        step();
        step();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL en_grant: got gnt=%b id=%0d, expected gnt=0100 id=2", gnt, gnt_id);
        end
        en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (gnt !== 4'b0 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || hold_cnt !== 4'd0) begin
                errors++;
                $display("FAIL en_off cyc%0d: got gnt=%b vld=%b id=%0d cnt=%0d, expected all zero", c, gnt, gnt_vld, gnt_id, hold_cnt);
            end
        end
        en = 1'b1; req = 4'b1111;
        step();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL en_resume: got gnt=%b id=%0d vld=%b, expected gnt=1000 id=3 vld=1", gnt, gnt_id, gnt_vld);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1; req = 4'b0001;
        step();
        step();
        checks++;
        if (gnt !== 4'b0001 || hold_cnt !== 4'd1) begin
            errors++;
            $display("FAIL areset_pre: got gnt=%b cnt=%0d, expected gnt=0001 cnt=1", gnt, hold_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, gnt_id, gnt_vld, hold_cnt} !== 11'b0) begin
            errors++;
            $display("FAIL areset_immediate: got gnt=%b id=%0d vld=%b cnt=%0d, expected all zero", gnt, gnt_id, gnt_vld, hold_cnt);
        end
        step();
        rst_n = 1'b1; req = 4'b1110;
        step();
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || hold_cnt !== 4'd0) begin
            errors++;
            $display("FAIL areset_after: got gnt=%b id=%0d cnt=%0d, expected gnt=0010 id=1 cnt=0", gnt, gnt_id, hold_cnt);
        end
    endtask

    task automatic test_hold_one();
        logic [3:0] exp_g;
        apply_reset();
        en1 = 1'b1; req1 = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            step();
            exp_g = 4'b0001 << (c % 4);
            checks++;
            if (gnt1 !== exp_g || gnt_id1 !== 2'(c % 4) || hold_cnt1 !== 1'b0 || !$onehot0(gnt1) || gnt_vld1 !== 1'b1) begin
                errors++;
                $display("FAIL hold1 cyc%0d: got gnt=%b id=%0d cnt=%0d vld=%b, expected gnt=%b id=%0d cnt=0 vld=1",
                         c, gnt1, gnt_id1, hold_cnt1, gnt_vld1, exp_g, c % 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_owner();
        test_owner_drop();
        test_enable();
        test_async_reset();
        test_hold_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
